seg_capture: RTL and testbench
==============================

SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..15: consecutive identical samples needed before a digit is latched.
REQ-002 Port clk, input, 1: single clock; all state on rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port seg_cat, input, 7: active-low segment cathodes [6:0] = g,f,e,d,c,b,a from the multiplexed display bus.
REQ-005 Port an, input, 4: active-low digit anodes; an[i]=0 selects digit i.
REQ-006 Port clr, input, 1: synchronous clear of captured digits, valid flags, frame mask and error count.
REQ-007 Port digits, output, 16: captured BCD digits; digits[4i+3:4i] holds digit i.
REQ-008 Port dig_valid, output, 4: dig_valid[i]=1 once digit i holds a captured value since reset/clr.
REQ-009 Port frame_done, output, 1: one-cycle pulse when all four digits captured since last pulse.
REQ-010 Port pat_err, output, 1: one-cycle pulse on latch of an undecodable pattern.
REQ-011 Port err_count, output, 8: saturating count of pat_err pulses.

Function
REQ-012 seg_cat and an SHALL be registered once; all decisions use registered samples.
REQ-013 Sample is "selected" only when exactly one bit of registered an is 0; zero or multiple low bits is blanking.
REQ-014 Decode table (seg_cat -> BCD): 7'd64->0, 121->1, 36->2, 48->3, 25->4, 18->5, 2->6, 120->7, 0->8, 16->9; all other patterns -> 4'hF with error.
REQ-015 FSM states: IDLE (blanking), TRACK (counting stability), HELD (digit latched, waiting for change).
REQ-016 IDLE->TRACK on a selected sample; stability counter loads 1, reference sample (an, seg_cat) stored.
REQ-017 TRACK: sample equal to reference increments counter; differing selected sample reloads reference and counter=1; blanking -> IDLE.
REQ-018 TRACK->HELD when counter reaches STABLE_CYCLES; on that same edge digits[i], dig_valid[i] and frame mask bit i update.
REQ-019 HELD: no further latch while sample equals reference; differing selected sample -> TRACK (counter=1); blanking -> IDLE.
REQ-020 Latency: digit updates on the edge STABLE_CYCLES+1 cycles after the first edge sampling the new stable input (one input register + STABLE_CYCLES samples).
REQ-021 Undecodable latch SHALL write 4'hF to digit i, set dig_valid[i], pulse pat_err, increment err_count unless at 255.
REQ-022 When frame mask becomes 4'b1111, frame_done SHALL pulse on the following cycle and mask clears; mask bit set on that same clearing edge is retained.
REQ-023 clr has priority over a simultaneous latch: latch discarded, FSM -> IDLE, no pat_err/frame_done pulse.
REQ-024 Re-latching an already-valid digit overwrites it; mask bit already set stays set.

Reset
REQ-025 On rst_n=0: digits=16'h0000, dig_valid=4'b0000, frame_done=0, pat_err=0, err_count=0, FSM=IDLE, counter=0, mask=0, input register=blanking (an=4'hF).
REQ-026 Reset mid-TRACK SHALL discard the partial count; capture restarts from IDLE after release.

Configuration
REQ-027 Macro SEG_CAPTURE_FILTER_EN defined: stability filter per REQ-016..REQ-019 with STABLE_CYCLES.
REQ-028 Macro SEG_CAPTURE_FILTER_EN undefined: latch on first selected sample differing from reference (effective STABLE_CYCLES=1, latency 2 cycles); FSM is IDLE/HELD only; parameter ignored.

Verification
REQ-029 Filter on, STABLE_CYCLES=4: an=4'b1110, seg_cat=7'd48 held 6 cycles -> digits[3:0]=3, dig_valid=4'b0001 on 5th edge, exactly one latch.
REQ-030 Scan digits 0..3 with patterns 121,36,18,16 each 5 cycles -> digits=16'h9521, frame_done single pulse one cycle after last latch, dig_valid=4'hF.
REQ-031 seg_cat=7'd127 on an=4'b1101 for 5 cycles -> digits[7:4]=4'hF, pat_err pulse, err_count=1; 300 such latches -> err_count=255.
REQ-032 Glitch: stable 7'd64 for 3 cycles, one cycle 7'd2, then 7'd64 -> no latch until 4 further stable samples; an=4'b1100 or 4'b1111 never latches.
REQ-033 clr asserted on latch edge -> digits/dig_valid/err_count=0, no pulses; rst_n low mid-TRACK -> all outputs per REQ-025.
REQ-034 Filter off: an=4'b0111, seg_cat=7'd120 -> digits[15:12]=7 two edges after drive.

Source files
------------

// File: rtl/seg_capture.sv
// Captures BCD digits by snooping a multiplexed active-low 7-segment display bus.
// Define SEG_CAPTURE_FILTER_EN to require STABLE_CYCLES identical samples before a latch.
module seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_cat,
  input  logic [3:0]  an,
  input  logic        clr,
  output logic [15:0] digits,
  output logic [3:0]  dig_valid,
  output logic        frame_done,
  output logic        pat_err,
  output logic [7:0]  err_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] HELD  = 2'd2;

`ifdef SEG_CAPTURE_FILTER_EN
  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);
`else
  // Unfiltered: every new selected sample latches at once, so TRACK is never entered.
  localparam logic [3:0] STABLE_N = 4'd1;
`endif

  logic [3:0] an_reg;
  logic [6:0] seg_reg;
  logic [1:0] state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [3:0] ref_an_reg, ref_an_next;
  logic [6:0] ref_seg_reg, ref_seg_next;
  logic [3:0] mask;
  logic       frame_done_reg, pat_err_reg;
  logic [7:0] err_count_reg;

  logic       sel, same, latch, dec_err;
  logic [1:0] sel_idx;
  logic [3:0] dec_val;

  always_comb begin
    sel     = 1'b1;
    sel_idx = 2'd0;
    case (an_reg)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel = 1'b0;
    endcase
  end

  assign same = sel && (an_reg == ref_an_reg) && (seg_reg == ref_seg_reg);

  always_comb begin
    dec_err = 1'b0;
    dec_val = 4'hF;
    case (seg_reg)
      7'd64:   dec_val = 4'd0;
      7'd121:  dec_val = 4'd1;
      7'd36:   dec_val = 4'd2;
      7'd48:   dec_val = 4'd3;
      7'd25:   dec_val = 4'd4;
      7'd18:   dec_val = 4'd5;
      7'd2:    dec_val = 4'd6;
      7'd120:  dec_val = 4'd7;
      7'd0:    dec_val = 4'd8;
      7'd16:   dec_val = 4'd9;
      default: dec_err = 1'b1;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    ref_an_next  = ref_an_reg;
    ref_seg_next = ref_seg_reg;
    latch        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel) begin
          ref_an_next  = an_reg;
          ref_seg_next = seg_reg;
          cnt_next     = 4'd1;
          if (STABLE_N == 4'd1) begin
            latch      = 1'b1;
            state_next = HELD;
          end else begin
            state_next = TRACK;
          end
        end
      end
      TRACK: begin
        if (!sel) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (same) begin
          cnt_next = cnt_reg + 4'd1;
          if (cnt_reg + 4'd1 == STABLE_N) begin
            latch      = 1'b1;
            state_next = HELD;
          end
        end else begin
          ref_an_next  = an_reg;
          ref_seg_next = seg_reg;
          cnt_next     = 4'd1;
        end
      end
      HELD: begin
        if (!sel) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (!same) begin
          ref_an_next  = an_reg;
          ref_seg_next = seg_reg;
          cnt_next     = 4'd1;
          if (STABLE_N == 4'd1) latch = 1'b1;
          else                  state_next = TRACK;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg         <= 4'hF;
      seg_reg        <= 7'h7F;
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      ref_an_reg     <= 4'hF;
      ref_seg_reg    <= 7'h7F;
      frame_done_reg <= 1'b0;
      pat_err_reg    <= 1'b0;
      err_count_reg  <= 8'd0;
    end else begin
      an_reg  <= an;
      seg_reg <= seg_cat;
      if (clr) begin
        state_reg      <= IDLE;
        cnt_reg        <= 4'd0;
        frame_done_reg <= 1'b0;
        pat_err_reg    <= 1'b0;
        err_count_reg  <= 8'd0;
      end else begin
        state_reg      <= state_next;
        cnt_reg        <= cnt_next;
        ref_an_reg     <= ref_an_next;
        ref_seg_reg    <= ref_seg_next;
        frame_done_reg <= (mask == 4'hF);
        pat_err_reg    <= latch && dec_err;
        if (latch && dec_err && err_count_reg != 8'hFF)
          err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] dig_reg;
      logic       valid_reg;
      logic       mask_reg;
      logic       hit;

      assign hit = latch && (sel_idx == 2'(gi));

      // A bit latched on the frame-clearing edge survives into the next frame.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dig_reg   <= 4'd0;
          valid_reg <= 1'b0;
          mask_reg  <= 1'b0;
        end else if (clr) begin
          dig_reg   <= 4'd0;
          valid_reg <= 1'b0;
          mask_reg  <= 1'b0;
        end else if (hit) begin
          dig_reg   <= dec_val;
          valid_reg <= 1'b1;
          mask_reg  <= 1'b1;
        end else if (mask == 4'hF) begin
          mask_reg  <= 1'b0;
        end
      end

      assign digits[4*gi +: 4] = dig_reg;
      assign dig_valid[gi]     = valid_reg;
      assign mask[gi]          = mask_reg;
    end
  endgenerate

  assign frame_done = frame_done_reg;
  assign pat_err    = pat_err_reg;
  assign err_count  = err_count_reg;

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture; expected state is computed per stimulus segment.
module tb_seg_capture;

`ifdef SEG_CAPTURE_FILTER_EN
  localparam int S = 4;
`else
  localparam int S = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_cat;
  logic [3:0]  an;
  logic        clr;
  logic [15:0] digits;
  logic [3:0]  dig_valid;
  logic        frame_done;
  logic        pat_err;
  logic [7:0]  err_count;

  seg_capture #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_cat(seg_cat), .an(an), .clr(clr),
    .digits(digits), .dig_valid(dig_valid), .frame_done(frame_done),
    .pat_err(pat_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  v;
    logic [7:0]  e;
    int          f;
    int          p;
  } snap_t;

  snap_t sb[$];

  int chk_cnt = 0;
  int pass_cnt = 0;
  int frame_seen = 0;
  int pat_seen = 0;

  logic [15:0] exp_dig = '0;
  logic [3:0]  exp_valid = '0;
  logic [7:0]  exp_err = '0;
  logic [3:0]  exp_mask = '0;
  int          exp_frames = 0;
  int          exp_paterr = 0;

  logic [6:0] pat_tab [10] = '{7'd64, 7'd121, 7'd36, 7'd48, 7'd25, 7'd18, 7'd2, 7'd120, 7'd0, 7'd16};

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) frame_seen++;
      if (pat_err)    pat_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_seg(input logic [3:0] a, input logic [6:0] s, input int n);
    int idx;
    logic [3:0] d;
    idx = -1;
    case (a)
      4'b1110: idx = 0;
      4'b1101: idx = 1;
      4'b1011: idx = 2;
      4'b0111: idx = 3;
      default: idx = -1;
    endcase
    if (idx >= 0 && n >= S) begin
      d = 4'hF;
      for (int k = 0; k < 10; k++)
        if (pat_tab[k] == s) d = 4'(k);
      exp_dig[idx*4 +: 4] = d;
      exp_valid[idx] = 1'b1;
      if (d == 4'hF) begin
        exp_paterr++;
        if (exp_err != 8'hFF) exp_err++;
      end
      exp_mask[idx] = 1'b1;
      if (exp_mask == 4'hF) begin
        exp_frames++;
        exp_mask = '0;
      end
    end
  endtask

  task automatic seg_drive(input logic [3:0] a, input logic [6:0] s, input int n);
    model_seg(a, s, n);
    an = a;
    seg_cat = s;
    repeat (n) tick();
  endtask

  task automatic checkpoint(input string tag);
    snap_t e;
    sb.push_back('{exp_dig, exp_valid, exp_err, exp_frames, exp_paterr});
    an = 4'hF;
    seg_cat = 7'h7F;
    repeat (3) tick();
    e = sb.pop_front();
    chk({tag, " digits"}, 32'(digits), 32'(e.d));
    chk({tag, " dig_valid"}, 32'(dig_valid), 32'(e.v));
    chk({tag, " err_count"}, 32'(err_count), 32'(e.e));
    chk({tag, " frames"}, 32'(frame_seen), 32'(e.f));
    chk({tag, " pat_errs"}, 32'(pat_seen), 32'(e.p));
    $display("checkpoint %s: digits=%h valid=%b err=%0d frames=%0d", tag, digits, dig_valid, err_count, frame_seen);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " digits"}, 32'(digits), 32'h0);
    chk({tag, " dig_valid"}, 32'(dig_valid), 32'h0);
    chk({tag, " err_count"}, 32'(err_count), 32'h0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'h0);
    chk({tag, " pat_err"}, 32'(pat_err), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    an = 4'hF;
    seg_cat = 7'h7F;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Latency: digit 0 = 3 appears exactly S+1 edges after drive.
    model_seg(4'b1110, 7'd48, 6);
    an = 4'b1110;
    seg_cat = 7'd48;
    repeat (S) tick();
    chk("latency early valid", 32'(dig_valid), 32'h0);
    tick();
    chk("latency valid", 32'(dig_valid), 32'h1);
    chk("latency digit", 32'(digits[3:0]), 32'h3);
    repeat (6 - S - 1) tick();
    checkpoint("stable6");

    // Scan all four digits back to back.
    seg_drive(4'b1110, 7'd121, 5);
    seg_drive(4'b1101, 7'd36, 5);
    seg_drive(4'b1011, 7'd18, 5);
    seg_drive(4'b0111, 7'd16, 5);
    checkpoint("scan");

    // Undecodable pattern, then saturate the error counter.
    seg_drive(4'b1101, 7'd127, 5);
    checkpoint("bad_pat");
    for (int i = 0; i < 300; i++) begin
      seg_drive(4'b1101, 7'd127, S);
      seg_drive(4'hF, 7'h7F, 1);
    end
    checkpoint("err_sat");

    // Clear coinciding with a latch edge wins.
    an = 4'b1011;
    seg_cat = 7'd127;
    repeat (S) tick();
    clr = 1'b1;
    an = 4'hF;
    seg_cat = 7'h7F;
    tick();
    clr = 1'b0;
    exp_dig = '0;
    exp_valid = '0;
    exp_err = '0;
    exp_mask = '0;
    checkpoint("clr");

    // Glitch and blanking patterns.
    seg_drive(4'b1110, 7'd64, 3);
    seg_drive(4'b1110, 7'd2, 1);
    seg_drive(4'b1110, 7'd64, 5);
    seg_drive(4'b1100, 7'd48, 5);
    seg_drive(4'b1111, 7'd48, 5);
    checkpoint("glitch");

    // Reset mid-capture discards the partial count.
    an = 4'b0111;
    seg_cat = 7'd120;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    exp_dig = '0;
    exp_valid = '0;
    exp_err = '0;
    exp_mask = '0;
    tick();
    rst_n = 1'b1;
    model_seg(4'b0111, 7'd120, S + 1);
    repeat (S) tick();
    chk("post_rst early valid", 32'(dig_valid), 32'h0);
    tick();
    chk("post_rst digit3", 32'(digits[15:12]), 32'h7);
    checkpoint("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
